// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 codes,
// one-hot ram write-enable encodings, FSM state encoding and an
// access-size helper.
package load_store_unit_pkg;

  // funct3 codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // ram write_enable encodings (one-hot or zero)
  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Number of bytes touched by an access with the given funct3.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3)
      F3_H, F3_HU: access_bytes = 3'd2;
      F3_W:        access_bytes = 3'd4;
      default:     access_bytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational datapath of the load/store unit.
//   - error check (illegal funct3, store with funct3[2]=1, out of range,
//     and misalignment when LSU_MISALIGN_TRAP_EN is defined)
//   - store lane placement and write_enable selection
//   - load byte/half extraction with sign or zero extension
// Ports:
//   we, funct3, addr, wdata : latched request fields
//   mem_rdata               : ram data_out, {mem[a],mem[a+1],mem[a+2],mem[a+3]}
//   err                     : request is rejected
//   store_we, store_data    : ram write_enable / data_in for a legal store
//   load_data               : extended load result (0 for stores and errors)
// Optional: LSU_MISALIGN_TRAP_EN makes misaligned H/HU/W accesses errors.
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 32
) (
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic              err,
  output logic [2:0]        store_we,
  output logic [31:0]       store_data,
  output logic [31:0]       load_data
);

  logic            illegal_f3;
  logic            bad_store;
  logic            out_of_range;
  logic            misaligned;
  logic [ADDR_W:0] last_byte;

  // NOTE: every output of this block gets a default before any branch,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    illegal_f3 = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    bad_store  = we && funct3[2];
    // One extra bit so an access near 0xFFFFFFFF cannot wrap back into range.
    last_byte    = {1'b0, addr} + (ADDR_W+1)'(access_bytes(funct3)) - (ADDR_W+1)'(1);
    out_of_range = last_byte >= (ADDR_W+1)'(MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                 ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
    // The ram is byte-addressed, so misaligned accesses are simply performed.
    misaligned = 1'b0;
`endif
    err = illegal_f3 || bad_store || out_of_range || misaligned;

    store_we   = WE_NONE;
    store_data = '0;
    if (we && !err) begin
      case (funct3)
        F3_W: begin store_we = WE_WORD; store_data = wdata;                  end
        F3_H: begin store_we = WE_HALF; store_data = {16'h0, wdata[15:0]};  end
        F3_B: begin store_we = WE_BYTE; store_data = {24'h0, wdata[7:0]};   end
        default: ;
      endcase
    end

    // Big-endian ram: the addressed byte sits in data_out[31:24].
    load_data = '0;
    if (!we && !err) begin
      case (funct3)
        F3_W:  load_data = mem_rdata;
        F3_H:  load_data = {{16{mem_rdata[31]}}, mem_rdata[31:16]};
        F3_HU: load_data = {16'h0, mem_rdata[31:16]};
        F3_B:  load_data = {{24{mem_rdata[31]}}, mem_rdata[31:24]};
        F3_BU: load_data = {24'h0, mem_rdata[31:24]};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory-access initiator between the
// execute stage and a byte-addressed, big-endian data ram.
//   req_*   : valid/ready request (we, funct3, addr, wdata), accepted in IDLE
//   resp_*  : valid/ready response (rdata, err), held stable until taken
//   mem_*   : ram addr / write_enable (one-hot W,H,B) / data_in, data_out
// FSM IDLE -> ACCESS (one cycle, ram read or write) -> RESP.
// Optional: LSU_MISALIGN_TRAP_EN (see lsu_align) traps misaligned H/W.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 2048,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_write_enable,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              align_err;
  logic [2:0]        align_we;
  logic [31:0]       align_wdata;
  logic [31:0]       align_rdata;

  lsu_align #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_align (
    .we         (we_q),
    .funct3     (funct3_q),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .mem_rdata  (mem_data_out),
    .err        (align_err),
    .store_we   (align_we),
    .store_data (align_wdata),
    .load_data  (align_rdata)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid)  state_d = ST_ACCESS;
      ST_ACCESS:                 state_d = ST_RESP;
      ST_RESP:   if (resp_ready) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // Outputs. The write enable is decoded from state, so an asynchronous
  // reset during ACCESS removes it before the closing edge.
  always_comb begin
    req_ready        = (state_q == ST_IDLE);
    resp_valid       = (state_q == ST_RESP);
    mem_write_enable = WE_NONE;
    mem_data_in      = '0;
    if (state_q == ST_ACCESS) begin
      mem_write_enable = align_we;
      mem_data_in      = align_wdata;
    end
  end

  assign mem_addr   = addr_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Request capture in IDLE, result capture at the end of ACCESS.
  always_comb begin
    we_d         = we_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    if ((state_q == ST_IDLE) && req_valid) begin
      we_d     = req_we;
      funct3_d = req_funct3;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end
    if (state_q == ST_ACCESS) begin
      resp_rdata_d = align_rdata;
      resp_err_d   = align_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit. A byte-array ram sits on the
// mem_* pins; a separate reference memory plus a transaction-level model
// predicts every response and every write-enable pulse.
module tb_load_store_unit;

  localparam int MEM_BYTES = 2048;
  localparam int ADDR_W    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [2:0]  mem_write_enable;
  logic [31:0] mem_data_in, mem_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // ---------------- ram environment ----------------
  logic [7:0] seed_mem [MEM_BYTES];
  logic [7:0] ram      [MEM_BYTES];
  logic [7:0] ref_mem  [MEM_BYTES];
  logic       ram_load;
  int         wr_n;
  logic [31:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++)
      if ({1'b0, mem_addr} + 33'(i) < 33'(MEM_BYTES))
        rd_word[31-8*i -: 8] = ram[mem_addr[10:0] + 11'(i)];
  end
  assign mem_data_out = rd_word;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < MEM_BYTES; i++) ram[i] <= seed_mem[i];
    end else begin
      wr_n = (mem_write_enable == 3'b001) ? 4 :
             (mem_write_enable == 3'b010) ? 2 :
             (mem_write_enable == 3'b100) ? 1 : 0;
      for (int i = 0; i < 4; i++)
        if (i < wr_n && ({1'b0, mem_addr} + 33'(i) < 33'(MEM_BYTES)))
          ram[mem_addr[10:0] + 11'(i)] <= mem_data_in[8*(wr_n-1-i) +: 8];
    end
  end

  // ---------------- reference model ----------------
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                       output logic [2:0] wen, output logic [31:0] din);
    int unsigned     n;
    longint unsigned last;
    logic [31:0]     v, mask;
    logic            legal;
    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (we && f3[2]) legal = 1'b0;
    n    = (f3 == 3'd2) ? 4 : ((f3 == 3'd1) || (f3 == 3'd5)) ? 2 : 1;
    last = 64'(addr) + 64'(n) - 64'd1;
    err  = !legal || (last >= 64'(MEM_BYTES));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((n == 2 && addr % 2 != 0) || (n == 4 && addr % 4 != 0)) err = 1'b1;
`endif
    mask  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    rdata = '0;
    wen   = 3'b000;
    din   = '0;
    if (!err) begin
      if (we) begin
        for (int k = 0; k < int'(n); k++)
          ref_mem[int'(addr) + k] = 8'((wdata >> (8*(int'(n)-1-k))) & 32'hFF);
        wen = (n == 4) ? 3'b001 : (n == 2) ? 3'b010 : 3'b100;
        din = wdata & mask;
      end else begin
        v = '0;
        for (int k = 0; k < int'(n); k++) v = (v << 8) | 32'(ref_mem[int'(addr) + k]);
        if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | ~mask;
        rdata = v;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete transaction; hold = cycles resp_ready stays low in RESP.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    logic        e_err;
    logic [31:0] e_rd, e_din;
    logic [2:0]  e_wen;
    model(we, f3, addr, wdata, e_err, e_rd, e_wen, e_din);
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    check("access_req_ready", 32'(req_ready), 32'd0);
    check("access_write_enable", 32'(mem_write_enable), 32'(e_wen));
    if (e_wen != 3'b000) begin
      check("access_mem_addr", mem_addr, addr);
      check("access_mem_data_in", mem_data_in, e_din);
    end
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_write_enable_off", 32'(mem_write_enable), 32'd0);
    check("resp_err", 32'(resp_err), 32'(e_err));
    check("resp_rdata", resp_rdata, e_rd);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_resp_valid", 32'(resp_valid), 32'd1);
      check("hold_resp_rdata", resp_rdata, e_rd);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("after_resp_valid", 32'(resp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] a, w;
    logic [2:0]  f;
    for (int i = 0; i < MEM_BYTES; i++) begin
      seed_mem[i] = 8'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    ram_load = 1'b1;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;

    #3;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_we", 32'(mem_write_enable), 32'd0);
    check("rst_mem_data_in", mem_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0; ram_load = 1'b0;

    // Directed sequence
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);   // SW
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);          // LW
    do_req(1'b0, 3'b000, 32'h10, 32'h0, 0);          // LB
    do_req(1'b0, 3'b100, 32'h11, 32'h0, 0);          // LBU
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 0);          // LH
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 0);          // LHU
    do_req(1'b1, 3'b000, 32'h13, 32'h12345678, 0);   // SB
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 3);          // LW with backpressure
    do_req(1'b1, 3'b010, 32'h11, 32'hCAFEF00D, 0);   // misaligned SW
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    do_req(1'b0, 3'b010, 32'h14, 32'h0, 0);
    do_req(1'b1, 3'b010, 32'h7FE, 32'h11223344, 0);  // out of range
    do_req(1'b1, 3'b000, 32'h7FF, 32'h000000A5, 0);  // last byte ok
    do_req(1'b0, 3'b000, 32'h7FF, 32'h0, 0);
    do_req(1'b0, 3'b011, 32'h20, 32'h0, 0);          // illegal funct3
    do_req(1'b1, 3'b100, 32'h20, 32'h55, 0);         // store with funct3[2]
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0);    // no wrap-around
    do_req(1'b0, 3'b001, 32'h7FF, 32'h0, 0);         // half straddles end

    // Reset during the ACCESS cycle of a store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hA5A5A5A5;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_access_we_before", 32'(mem_write_enable), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_access_we", 32'(mem_write_enable), 32'd0);
    check("rst_access_req_ready", 32'(req_ready), 32'd1);
    check("rst_access_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_access_mem_addr", mem_addr, 32'd0);
    check("rst_access_data_in", mem_data_in, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) check("rst_mem_unchanged", 32'(ram[32'h40 + k]), 32'(ref_mem[32'h40 + k]));
    do_req(1'b0, 3'b010, 32'h40, 32'h0, 0);

    // Randomized traffic
    for (int t = 0; t < 120; t++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       a = MEM_BYTES - 6 + $urandom_range(0, 7);
        1:       a = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: a = $urandom_range(0, 63);
      endcase
      w = $urandom;
      do_req(1'($urandom_range(0, 1)), f, a, w, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access initiator between the RISC-V core's execute stage and the byte-addressed data `ram`.
- Accepts one load/store request at a time over a valid/ready handshake.
- Drives the ram's `addr`/`write_enable`/`data_in` pins, samples its combinational `data_out`, and returns aligned, sign/zero-extended load data or an error flag.
- Memory byte order is big-endian: byte at `addr` is the most significant.

Parameters:
- MEM_BYTES, 2048, size of the data ram in bytes; accesses past `MEM_BYTES-1` are errors.
- ADDR_W, 32, width of request and memory address.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  unit can accept (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  input  ADDR_W  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  response present
- resp_ready  input  1  consumer takes response
- resp_rdata  output  32  load result; 0 for stores and errors
- resp_err  output  1  misaligned, out-of-range or illegal funct3
- mem_addr  output  ADDR_W  to ram addr
- mem_write_enable  output  3  to ram: bit0 word, bit1 half, bit2 byte (one-hot or zero)
- mem_data_in  output  32  to ram data_in
- mem_data_out  input  32  from ram data_out, {mem[a],mem[a+1],mem[a+2],mem[a+3]}

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE.
  - resp_valid, resp_err, resp_rdata, mem_addr, mem_data_in = 0.
  - mem_write_enable = 3'b000.
  - req_ready = 1.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch we/funct3/addr/wdata and compute the error flag, then go to ACCESS.
- ACCESS (one cycle):
  - mem_addr = latched addr.
  - Store without error: mem_write_enable = 001 (W), 010 (H) or 100 (B) for exactly this cycle, so the ram writes on the closing edge.
    - W: mem_data_in = wdata.
    - H: mem_data_in[15:0] = wdata[15:0].
    - B: mem_data_in[7:0] = wdata[7:0].
    - Upper bits of mem_data_in are 0.
  - Load without error: register the result at the closing edge.
    - W = mem_data_out.
    - H = sext(mem_data_out[31:16]); HU = zext of the same.
    - B = sext(mem_data_out[31:24]); BU = zext of the same.
  - Always go to RESP.
- Any error: mem_write_enable stays 000, resp_rdata = 0, resp_err = 1.
- RESP:
  - resp_valid = 1; resp_rdata/resp_err held stable until resp_ready.
  - On resp_ready, go to IDLE.
- Latency: accept at edge N, write or read at edge N+1, resp_valid high after N+1. Throughput is one request per 3 cycles minimum.
- Error conditions:
  - funct3 in {011, 110, 111}.
  - Store with funct3[2] = 1.
  - addr + size - 1 ≥ MEM_BYTES (compare in ADDR_W+1 bits, so there is no wrap-around at 0xFFFFFFFF).
- req_valid in ACCESS/RESP is ignored (req_ready = 0); the request must be held by the source.
- Reset in ACCESS: mem_write_enable drops asynchronously. It is derived from state, so no write occurs if rst is high at the edge.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: H/HU with addr[0] ≠ 0, or W with addr[1:0] ≠ 0, is an error; no write, resp_err = 1.
- LSU_MISALIGN_TRAP_EN undefined: misaligned accesses are performed as issued, since the ram is byte-addressed. Only the range and funct3 checks raise resp_err.

Decomposition:
- Shared include `instructions.vh`: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), write_enable one-hot encodings (WE_WORD, WE_HALF, WE_BYTE), and LSU state encodings.
- One natural sub-module: lsu_align. It is purely combinational and holds:
  - store lane/write_enable generation;
  - load extraction and sign-extension;
  - the error check.
- The FSM stays in load_store_unit.

Test Plan:
- SW addr 0x10 wdata 0xDEADBEEF -> exactly one cycle mem_write_enable = 001 with mem_data_in = 0xDEADBEEF; then resp_valid, resp_err = 0. A following LW 0x10 -> resp_rdata 0xDEADBEEF.
- After the above:
  - LB 0x10 -> 0xFFFFFFDE.
  - LBU 0x11 -> 0x000000AD.
  - LH 0x12 -> 0xFFFFBEEF.
  - LHU 0x12 -> 0x0000BEEF.
- SB 0x13 wdata 0x12345678 -> mem_write_enable = 100, mem_data_in = 0x00000078; then LW 0x10 -> 0xDEADBE78.
- With LSU_MISALIGN_TRAP_EN, SW 0x11 -> no write-enable pulse, resp_err = 1; LW 0x10 still 0xDEADBE78. Without it, the same SW writes mem[0x11..0x14].
- MEM_BYTES = 2048:
  - SW 0x7FE -> resp_err = 1, no write.
  - SB 0x7FF -> ok.
  - funct3 = 011 -> resp_err = 1.
- Backpressure and reset:
  - Hold resp_ready low 3 cycles in RESP -> resp_valid/rdata stable, req_ready = 0.
  - Assert rst during ACCESS of an SW -> mem_write_enable goes to 000 immediately, memory unchanged, all outputs at reset values.
